flag_ccr_ctrl: RTL and testbench

- Condition-code register (CCR) controller for the 8-bit datapath. It owns the architectural N/Z/C/V register.
- Sequences per-instruction masked flag updates from the flag generator, explicit CCR writes, and interrupt entry/return save/restore.
- Save/restore uses a small shadow stack.
- Sits between the flag generator outputs and the branch/condition unit.

---
 rtl/flag_ccr_ctrl.sv | 113 +++++++++++
 tb/tb_flag_ccr_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/flag_ccr_ctrl.sv
// Condition-code register controller: masked flag updates, explicit writes and
// interrupt save/restore through a LIFO shadow stack. Define CCR_FWD_EN to forward next-ccr on ccr_fwd.
module flag_ccr_ctrl #(
  parameter int         DEPTH       = 4,
  parameter int         PTR_W       = 2,
  parameter logic [3:0] IRQ_CLR_VAL = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       upd_valid,
  input  logic [3:0] upd_mask,
  input  logic       flag_n,
  input  logic       flag_z,
  input  logic       flag_c,
  input  logic       flag_v,
  input  logic       wr_en,
  input  logic [3:0] wr_data,
  input  logic       push,
  input  logic       pop,
  input  logic       err_clr,
  output logic       ready,
  output logic [3:0] ccr,
  output logic [3:0] ccr_fwd,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       err_ovf,
  output logic       err_unf,
  output logic       collide
);

  typedef enum logic [1:0] {IDLE, IRQ_CLR, POP_HOLD} state_t;

  state_t           state;
  logic [PTR_W:0]   count;
  logic [3:0]       stack [DEPTH];
  logic [PTR_W-1:0] top_idx;
  logic [3:0]       events;
  logic [3:0]       flags;
  logic [3:0]       ccr_next;
  logic             do_pop, do_push, do_wr, do_upd;
  logic             pop_ok, push_ok, multi;

  assign ready       = (state == IDLE);
  assign stack_empty = (count == '0);
  assign stack_full  = (count == (PTR_W+1)'(DEPTH));
  assign top_idx     = count[PTR_W-1:0] - PTR_W'(1);
  assign flags       = {flag_n, flag_z, flag_c, flag_v};
  assign events      = {pop, push, wr_en, upd_valid};

  // Fixed priority pop > push > wr_en > upd_valid; only the winner acts.
  assign do_pop  = ready & pop;
  assign do_push = ready & push & ~pop;
  assign do_wr   = ready & wr_en & ~pop & ~push;
  assign do_upd  = ready & upd_valid & ~pop & ~push & ~wr_en;
  assign pop_ok  = do_pop & ~stack_empty;
  assign push_ok = do_push & ~stack_full;
  assign multi   = ready & ((events & (events - 4'd1)) != 4'd0);

  always_comb begin
    // NOTE: default assignment first so every path drives ccr_next and no latch is inferred.
    ccr_next = ccr;
    if (state == IRQ_CLR)
      ccr_next = IRQ_CLR_VAL;
    else if (pop_ok)
      ccr_next = stack[top_idx];
    else if (do_wr)
      ccr_next = wr_data;
    else if (do_upd)
      ccr_next = (ccr & ~upd_mask) | (flags & upd_mask);
  end

`ifdef CCR_FWD_EN
  assign ccr_fwd = ccr_next;
`else
  assign ccr_fwd = ccr;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ccr     <= 4'b0000;
      count   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
      collide <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ccr     <= ccr_next;
      collide <= multi;
      err_ovf <= (do_push & stack_full) | (err_ovf & ~err_clr);
      err_unf <= (do_pop & stack_empty) | (err_unf & ~err_clr);
      case (state)
        IDLE: begin
          if (pop_ok) begin
            count <= count - (PTR_W+1)'(1);
            state <= POP_HOLD;
          end else if (push_ok) begin
            count <= count + (PTR_W+1)'(1);
            state <= IRQ_CLR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: stack storage is not reset; entries above count are never read.
  always_ff @(posedge clk) begin
    if (push_ok)
      stack[count[PTR_W-1:0]] <= ccr;
  end

endmodule

// File: tb/tb_flag_ccr_ctrl.sv
// Self-checking bench for flag_ccr_ctrl: directed test-plan steps followed by
// random traffic, compared against a queue-based reference model.
module tb_flag_ccr_ctrl;

  localparam int         DEPTH       = 4;
  localparam logic [3:0] IRQ_CLR_VAL = 4'b0000;

  logic       clk = 1'b0;
  logic       reset;
  logic       upd_valid, wr_en, push, pop, err_clr;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic [3:0] upd_mask, wr_data;
  logic       ready, stack_full, stack_empty, err_ovf, err_unf, collide;
  logic [3:0] ccr, ccr_fwd;

  flag_ccr_ctrl #(.DEPTH(DEPTH), .PTR_W(2), .IRQ_CLR_VAL(IRQ_CLR_VAL)) dut (
    .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_mask(upd_mask),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .wr_en(wr_en), .wr_data(wr_data), .push(push), .pop(pop), .err_clr(err_clr),
    .ready(ready), .ccr(ccr), .ccr_fwd(ccr_fwd), .stack_full(stack_full),
    .stack_empty(stack_empty), .err_ovf(err_ovf), .err_unf(err_unf), .collide(collide)
  );

  always #5 clk = ~clk;

  // Reference model: ccr value, saved values as a queue, remaining busy cycles.
  logic [3:0] m_ccr;
  logic [3:0] m_stk[$];
  int         m_busy;
  bit         m_clr_due;
  bit         m_ovf, m_unf, m_col;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ccr = 4'b0000;
    m_stk.delete();
    m_busy = 0;
    m_clr_due = 0;
    m_ovf = 0;
    m_unf = 0;
    m_col = 0;
  endtask

  task automatic check_outputs();
    check("ccr",         ccr,                   m_ccr);
    check("ready",       4'(ready),             4'(m_busy == 0));
    check("stack_full",  4'(stack_full),        4'(m_stk.size() == DEPTH));
    check("stack_empty", 4'(stack_empty),       4'(m_stk.size() == 0));
    check("err_ovf",     4'(err_ovf),           4'(m_ovf));
    check("err_unf",     4'(err_unf),           4'(m_unf));
    check("collide",     4'(collide),           4'(m_col));
  endtask

  task automatic drive_idle();
    pop = 0; push = 0; wr_en = 0; wr_data = 4'b0; upd_valid = 0; upd_mask = 4'b0;
    {flag_n, flag_z, flag_c, flag_v} = 4'b0; err_clr = 0;
  endtask

  task automatic step(input bit p_pop, input bit p_push, input bit p_wr, input logic [3:0] p_wd,
                      input bit p_upd, input logic [3:0] p_mask, input logic [3:0] p_flags,
                      input bit p_clr);
    logic [3:0] n_ccr;
    int         n_busy, nev;
    bit         n_clr_due, set_o, set_u, n_col, do_pop, do_push;
    pop = p_pop; push = p_push; wr_en = p_wr; wr_data = p_wd;
    upd_valid = p_upd; upd_mask = p_mask; err_clr = p_clr;
    {flag_n, flag_z, flag_c, flag_v} = p_flags;
    n_ccr = m_ccr; n_busy = m_busy; n_clr_due = m_clr_due;
    set_o = 0; set_u = 0; n_col = 0; do_pop = 0; do_push = 0;
    if (m_busy > 0) begin
      if (m_clr_due) n_ccr = IRQ_CLR_VAL;
      n_busy = m_busy - 1;
      n_clr_due = 0;
    end else begin
      nev = int'(p_pop) + int'(p_push) + int'(p_wr) + int'(p_upd);
      n_col = (nev > 1);
      if (p_pop) begin
        if (m_stk.size() > 0) begin
          n_ccr = m_stk[$]; do_pop = 1; n_busy = 1;
        end else set_u = 1;
      end else if (p_push) begin
        if (m_stk.size() < DEPTH) begin
          do_push = 1; n_busy = 1; n_clr_due = 1;
        end else set_o = 1;
      end else if (p_wr) begin
        n_ccr = p_wd;
      end else if (p_upd) begin
        for (int i = 0; i < 4; i++)
          if (p_mask[i]) n_ccr[i] = p_flags[i];
      end
    end
    @(negedge clk);
`ifdef CCR_FWD_EN
    check("ccr_fwd", ccr_fwd, n_ccr);
`else
    check("ccr_fwd", ccr_fwd, m_ccr);
`endif
    @(posedge clk);
    #1;
    if (do_pop)  void'(m_stk.pop_back());
    if (do_push) m_stk.push_back(m_ccr);
    m_ccr = n_ccr;
    m_busy = n_busy;
    m_clr_due = n_clr_due;
    m_col = n_col;
    m_ovf = set_o | (m_ovf & !p_clr);
    m_unf = set_u | (m_unf & !p_clr);
    check_outputs();
  endtask

  task automatic idle();
    step(0, 0, 0, 4'b0, 0, 4'b0, 4'b0, 0);
  endtask

  task automatic wr(input logic [3:0] d);
    step(0, 0, 1, d, 0, 4'b0, 4'b0, 0);
  endtask

  initial begin
    drive_idle();
    reset = 1'b0;
    m_reset();
    #12;
    check_outputs();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Masked flag updates
    step(0, 0, 0, 4'b0, 1, 4'b1111, 4'b1010, 0);
    step(0, 0, 0, 4'b0, 1, 4'b0100, 4'b0100, 0);
    step(0, 0, 0, 4'b0, 1, 4'b0000, 4'b0001, 0);

    // Push, IRQ clear, write, pop restore
    wr(4'b1010);
    step(0, 1, 0, 4'b0, 0, 4'b0, 4'b0, 0);
    idle();
    idle();
    wr(4'b0101);
    step(1, 0, 0, 4'b0, 0, 4'b0, 4'b0, 0);
    idle();

    // Fill the stack, overflow, drain in LIFO order
    for (int k = 0; k < DEPTH; k++) begin
      wr(4'(1 << k));
      step(0, 1, 0, 4'b0, 0, 4'b0, 4'b0, 0);
      idle();
      idle();
    end
    step(0, 1, 0, 4'b0, 0, 4'b0, 4'b0, 0);
    for (int k = 0; k < DEPTH; k++) begin
      step(1, 0, 0, 4'b0, 0, 4'b0, 4'b0, 0);
      idle();
    end

    // Underflow and sticky-error clearing
    step(1, 0, 0, 4'b0, 0, 4'b0, 4'b0, 0);
    step(0, 0, 0, 4'b0, 0, 4'b0, 4'b0, 1);
    step(1, 0, 0, 4'b0, 0, 4'b0, 4'b0, 1);
    step(0, 0, 0, 4'b0, 0, 4'b0, 4'b0, 1);

    // Collision: wr_en beats upd_valid
    step(0, 0, 1, 4'b1111, 1, 4'b1111, 4'b0000, 0);
    idle();

    // Reset during IRQ_CLR
    wr(4'b0110);
    step(0, 1, 0, 4'b0, 0, 4'b0, 4'b0, 0);
    drive_idle();
    #1 reset = 1'b0;
    #1 m_reset();
    check_outputs();
    #1 reset = 1'b1;
    idle();
    idle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
           4'($urandom), $urandom_range(0, 2) == 0, 4'($urandom), 4'($urandom),
           $urandom_range(0, 9) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
